// File: rtl/ip_codma_rd_engine_if.sv
// Bus-side handshake of the CODMA read engine: request/length out, grant/beat/error in.
interface ip_codma_rd_engine_if #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
);
  logic              bus_req;
  logic [LEN_W-1:0]  bus_len;
  logic              bus_grant;
  logic              bus_read_valid;
  logic [DATA_W-1:0] bus_read_data;
  logic              bus_error;

  modport master (
    output bus_req,
    output bus_len,
    input  bus_grant,
    input  bus_read_valid,
    input  bus_read_data,
    input  bus_error
  );

  modport slave (
    input  bus_req,
    input  bus_len,
    output bus_grant,
    output bus_read_valid,
    output bus_read_data,
    output bus_error
  );
endinterface

// File: rtl/ip_codma_rd_engine.sv
// CODMA read engine: arbitrates for the bus, then gathers a programmable number of
// words from multi-word read beats into a flat buffer, with done pulse and sticky error code.
module ip_codma_rd_engine #(
  parameter int  DATA_W     = 64,
  parameter int  WORD_W     = 32,
  parameter int  MAX_WORDS  = 8,
  parameter int  TIMEOUT    = 255,
  localparam int BEAT_WORDS = DATA_W / WORD_W,
  localparam int LEN_W      = $clog2(MAX_WORDS) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic                        stop_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [1:0]                  err_code_o,
  output logic [LEN_W-1:0]            word_count_o,
  output logic [MAX_WORDS*WORD_W-1:0] data_o,
  ip_codma_rd_engine_if.master        bus
);

  localparam int BEATS  = MAX_WORDS / BEAT_WORDS;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0]  BEAT_LEN  = LEN_W'(BEAT_WORDS);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_WORDS);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_ASK     = 3'd1,
    RD_GRANTED = 3'd2,
    RD_DONE    = 3'd3,
    RD_ERROR   = 3'd4
  } rd_state_e;

  rd_state_e          state_r, state_s;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   count_r;
  logic [TCNT_W-1:0]  tcnt_r;
  logic               error_r;
  logic [1:0]         err_code_r;
  logic [DATA_W-1:0]  beat_r [BEATS];

  logic               len_ok_s;
  logic               accept_s;
  logic               beat_wr_s;
  logic               err_set_s;
  logic [1:0]         err_code_s;
  logic [LEN_W-1:0]   count_next_s;
  logic [BIDX_W-1:0]  beat_idx_s;

  assign len_ok_s     = (len_i != LEN_W'(0)) && (len_i <= MAX_LEN) &&
                        ((len_i % BEAT_LEN) == LEN_W'(0));
  assign count_next_s = count_r + BEAT_LEN;
  assign beat_idx_s   = BIDX_W'(count_r / BEAT_LEN);

  // Next-state and per-cycle action decode; stop overrides everything else.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    beat_wr_s  = 1'b0;
    err_set_s  = 1'b0;
    err_code_s = 2'b00;
    if (stop_i) begin
      state_s = RD_IDLE;
    end else begin
      case (state_r)
        RD_IDLE: begin
          if (start_i && len_ok_s) begin
            state_s  = RD_ASK;
            accept_s = 1'b1;
          end else if (start_i) begin
            state_s    = RD_ERROR;
            err_set_s  = 1'b1;
            err_code_s = 2'b11;
          end else begin
            state_s = RD_IDLE;
          end
        end
        RD_ASK: begin
          if (bus.bus_error) begin
            state_s    = RD_ERROR;
            err_set_s  = 1'b1;
            err_code_s = 2'b01;
          end else if (bus.bus_grant) begin
            state_s = RD_GRANTED;
          end else begin
            state_s = RD_ASK;
          end
        end
        RD_GRANTED: begin
          // A bus error wins over a coincident beat, which is then dropped.
          if (bus.bus_error) begin
            state_s    = RD_ERROR;
            err_set_s  = 1'b1;
            err_code_s = 2'b01;
          end else if (bus.bus_read_valid) begin
            beat_wr_s = 1'b1;
            state_s   = (count_next_s == len_r) ? RD_DONE : RD_GRANTED;
          end else if (tcnt_r == TCNT_LAST) begin
            state_s    = RD_ERROR;
            err_set_s  = 1'b1;
            err_code_s = 2'b10;
          end else begin
            state_s = RD_GRANTED;
          end
        end
        RD_DONE:  state_s = RD_IDLE;
        RD_ERROR: state_s = RD_IDLE;
        default:  state_s = RD_IDLE;
      endcase
    end
  end

  // State, length, word count, beat-gap counter and sticky error registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= RD_IDLE;
      len_r      <= LEN_W'(0);
      count_r    <= LEN_W'(0);
      tcnt_r     <= TCNT_W'(0);
      error_r    <= 1'b0;
      err_code_r <= 2'b00;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        len_r      <= len_i;
        count_r    <= LEN_W'(0);
        error_r    <= 1'b0;
        err_code_r <= 2'b00;
      end else if (beat_wr_s) begin
        count_r <= count_next_s;
      end
      if (err_set_s) begin
        error_r    <= 1'b1;
        err_code_r <= err_code_s;
      end
      if ((state_r != RD_GRANTED) || beat_wr_s) begin
        tcnt_r <= TCNT_W'(0);
      end else begin
        tcnt_r <= tcnt_r + TCNT_W'(1);
      end
    end
  end

  // Beat-wide buffer slots; a beat always lands on a beat-aligned word index.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int b = 0; b < BEATS; b++) beat_r[b] <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      for (int b = 0; b < BEATS; b++) beat_r[b] <= {DATA_W{1'b0}};
    end else if (beat_wr_s) begin
      beat_r[beat_idx_s] <= bus.bus_read_data;
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_pack
    assign data_o[g*DATA_W +: DATA_W] = beat_r[g];
  end

  assign busy_o       = (state_r != RD_IDLE);
  assign done_o       = (state_r == RD_DONE);
  assign error_o      = error_r;
  assign err_code_o   = err_code_r;
  assign word_count_o = count_r;
  assign bus.bus_req  = (state_r == RD_ASK) || (state_r == RD_GRANTED);
  assign bus.bus_len  = len_r;

endmodule

// File: doc/ip_codma_rd_engine.md
# ip_codma_rd_engine

Parametrised read engine for CODMA: on a start request it arbitrates for the system bus, then collects a programmable number of 32-bit words from multi-word read beats into an output buffer. It reports completion with a done pulse, and reports bus errors, beat timeouts and illegal lengths with a sticky error code. It sits between the CODMA control FSM and the bus master port, and supersedes the fixed-size (2/6/8 word) read machine with a length-programmable, width-generic engine.

## Interface
Parameters:
- DATA_W, 64, bus read-data width; must be a multiple of WORD_W.
- WORD_W, 32, buffer word width.
- MAX_WORDS, 8, buffer depth in words; must be a multiple of BEAT_WORDS.
- TIMEOUT, 255, maximum cycles allowed in RD_GRANTED without a read_valid beat; must be ≥1.
- Derived: BEAT_WORDS = DATA_W/WORD_W; LEN_W = $clog2(MAX_WORDS)+1.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request; sampled only in RD_IDLE.
- len_i  in  LEN_W  word count, sampled with start_i.
- stop_i  in  1  abort; highest priority.
- busy_o  out  1  high in every state other than RD_IDLE.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  sticky error flag.
- err_code_o  out  2  error cause: 00 none, 01 bus error, 10 timeout, 11 bad length.
- word_count_o  out  LEN_W  words stored so far.
- data_o  out  MAX_WORDS*WORD_W  buffer; word k occupies bits [k*WORD_W +: WORD_W].
- bus_req_o  out  1  bus request; high in RD_ASK and RD_GRANTED.
- bus_len_o  out  LEN_W  latched length, presented to the bus while requesting.
- bus_grant_i  in  1  bus grant.
- bus_read_valid_i  in  1  read beat valid.
- bus_read_data_i  in  DATA_W  beat data; lowest word first.
- bus_error_i  in  1  bus error.

## Operation
- States: RD_IDLE, RD_ASK, RD_GRANTED, RD_DONE, RD_ERROR. The state is registered, and all outputs are driven from registers or from the current state.
- RD_IDLE to RD_ASK: start_i=1 and len_i is legal, meaning nonzero, ≤MAX_WORDS and a multiple of BEAT_WORDS.
  - Latch the length.
  - Clear data_o and word_count_o.
  - Clear error_o and err_code_o.
- RD_IDLE to RD_ERROR: start_i=1 with an illegal len_i; set err_code=11.
- RD_ASK to RD_GRANTED: bus_grant_i=1. read_valid is ignored while in RD_ASK.
- RD_GRANTED, each cycle with bus_read_valid_i=1:
  - Write BEAT_WORDS words at index word_count, from the lowest slice of the beat upward.
  - word_count += BEAT_WORDS.
  - If the new count equals the latched length, go to RD_DONE.
- RD_GRANTED timeout counter:
  - Cleared on entry to RD_GRANTED and on every valid beat; otherwise incremented.
  - When it reaches TIMEOUT with no valid beat in that cycle, go to RD_ERROR with err_code=10.
- RD_ASK or RD_GRANTED with bus_error_i=1: go to RD_ERROR with err_code=01. Error takes priority over a coincident valid beat, and that beat is not written.
- RD_DONE: done_o=1 for this single cycle, then RD_IDLE.
- RD_ERROR: error_o=1. Go to RD_IDLE next cycle. error_o and err_code_o hold until the next accepted start.
- stop_i=1 in any state: go to RD_IDLE next cycle.
  - No done_o, and no error is recorded.
  - Partial data and word_count are retained.
  - stop_i beats a coincident bus_error_i, valid beat or start_i.
- start_i outside RD_IDLE is ignored.

## Timing
- Reset values:
  - State RD_IDLE.
  - busy_o=0, done_o=0, error_o=0, err_code_o=00.
  - word_count_o=0, data_o=0.
  - bus_req_o=0, bus_len_o=0.
- Best-case latency with start at cycle 0 and grant high at cycle 1:
  - RD_GRANTED from cycle 2.
  - Beats on consecutive cycles 2..N+1, where N = len/BEAT_WORDS.
  - done_o at cycle N+2.
- Data and word_count_o are updated on the edge after the beat, so the final data is visible in the same cycle as done_o.
- Reset asserted mid-transfer returns all outputs to their reset values immediately (asynchronously).

## Test plan
- 8-word read, DATA_W=64: start len=8 at cycle 0, grant at cycle 1, beats 0x11110000_22220000 ... on cycles 2-5. Required: words 0/1 = 0x22220000/0x11110000, done_o at cycle 6 only, word_count_o=8.
- Illegal length: len=3 (odd) and len=10 (exceeds depth). Required: error_o=1, err_code_o=11, bus_req_o never asserted.
- Bus error on the 2nd beat of a len=6 read. Required: err_code_o=01, word_count_o=2, coincident beat data not stored, no done_o.
- Timeout: TIMEOUT=4, grant given, no valid beats. Required: RD_ERROR 4 cycles after entering RD_GRANTED, err_code_o=10. A subsequent legal start clears error_o.
- stop_i asserted together with bus_error_i mid-transfer. Required: RD_IDLE next cycle, error_o=0, done_o=0, partial data retained.
- Async reset mid-transfer, plus a start_i while busy. Required: all outputs return to reset values immediately; the start issued while busy is ignored.
